// File: rtl/mult_div_unit_pkg.sv
// Shared multiply/divide definitions: MD operation encodings and op-class helpers.
package mult_div_unit_pkg;

  typedef logic [2:0] md_op_t;

  localparam md_op_t MDU_NONE  = 3'd0;
  localparam md_op_t MDU_MULT  = 3'd1;
  localparam md_op_t MDU_MULTU = 3'd2;
  localparam md_op_t MDU_DIV   = 3'd3;
  localparam md_op_t MDU_DIVU  = 3'd4;
  localparam md_op_t MDU_MTHI  = 3'd5;
  localparam md_op_t MDU_MTLO  = 3'd6;

  function automatic logic is_div_op(md_op_t op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 32x32 multiply / divide datapath producing the 64-bit {HI,LO} result.
module mdu_calc
  import mult_div_unit_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        sgn;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic [31:0] quo;
  logic [31:0] rem;

  // Sign-extending to 64 bits makes the truncated product the signed result.
  assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  assign div_zero = is_div_op(md_op) && (src_b == 32'd0);

  // Signed division on magnitudes avoids the INT_MIN / -1 overflow of native signed divide.
  assign sgn   = (md_op == MDU_DIV);
  assign mag_a = (sgn && src_a[31]) ? (~src_a + 32'd1) : src_a;
  assign mag_b = (src_b == 32'd0) ? 32'd1 :
                 (sgn && src_b[31]) ? (~src_b + 32'd1) : src_b;
  assign quo_u = mag_a / mag_b;
  assign rem_u = mag_a % mag_b;
  assign quo   = (sgn && (src_a[31] ^ src_b[31])) ? (~quo_u + 32'd1) : quo_u;
  assign rem   = (sgn && src_a[31]) ? (~rem_u + 32'd1) : rem_u;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (md_op)
      MDU_MULT:           {res_hi, res_lo} = prod_s;
      MDU_MULTU:          {res_hi, res_lo} = prod_u;
      MDU_DIV, MDU_DIVU: begin
        res_hi = rem;
        res_lo = quo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage MD unit: owns HI/LO, runs fixed-latency multiply/divide, services MTHI/MTLO.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic StIdle = 1'b0;
  localparam logic StRun  = 1'b1;

  logic            state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic [31:0]     p_hi_q, p_hi_d;
  logic [31:0]     p_lo_q, p_lo_d;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_zero;
  logic        commit;
  logic        accept;

  mdu_calc u_calc (
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  assign commit = (state_q == StRun) && (cnt_q == CntW'(1));
  // The commit edge also frees the unit, so a new op may start on it.
  assign accept = start && ((state_q == StIdle) || commit);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;

    if (state_q == StRun) begin
      cnt_d = cnt_q - CntW'(1);
      if (commit) begin
        hi_d    = p_hi_q;
        lo_d    = p_lo_q;
        state_d = StIdle;
      end
    end

    if (accept) begin
      case (md_op)
        MDU_MULT, MDU_MULTU: begin
          p_hi_d  = res_hi;
          p_lo_d  = res_lo;
          cnt_d   = CntW'(MULT_CYCLES);
          state_d = StRun;
        end
        MDU_DIV, MDU_DIVU: begin
          // Divide by zero re-commits whatever HI/LO hold once this edge settles.
          p_hi_d  = div_zero ? hi_d : res_hi;
          p_lo_d  = div_zero ? lo_d : res_lo;
          cnt_d   = CntW'(DIV_CYCLES);
          state_d = StRun;
        end
        MDU_MTHI: hi_d = src_a;
        MDU_MTLO: lo_d = src_a;
        MDU_NONE: ;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      p_hi_q  <= 32'd0;
      p_lo_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
    end
  end

  assign busy = (state_q == StRun);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Execute-stage multiply/divide unit of the pipelined MIPS core. Owns the HI and LO registers, runs MULT/MULTU over a fixed multi-cycle latency and DIV/DIVU likewise, and services MTHI/MTLO writes. Its `hi`/`lo` outputs are the values forwarded downstream as the HI/LO sources. Its `busy` output feeds the stall controller, which holds any MD-class instruction in D while the unit is occupied.

## Interface
- `MULT_CYCLES`, 5, cycles `busy` stays high for MULT/MULTU (≥1)
- `DIV_CYCLES`, 10, cycles `busy` stays high for DIV/DIVU (≥1)

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle request from E stage; sampled at rising edge
- `md_op`  in  3  operation code: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO
- `src_a`  in  32  rs operand (already forwarded)
- `src_b`  in  32  rt operand (already forwarded)
- `busy`  out  1  computation in progress
- `hi`  out  32  architectural HI
- `lo`  out  32  architectural LO

## Operation
- States: IDLE, RUN. Down-counter `cnt` is wide enough for `max(MULT_CYCLES, DIV_CYCLES)`.
- In IDLE with `start=1`:
  - MULT/MULTU/DIV/DIVU: latch the 64-bit result into pending registers `p_hi`/`p_lo`. Load `cnt` with the op's latency and go to RUN.
  - MTHI: `hi<=src_a` at this edge; stay in IDLE.
  - MTLO: `lo<=src_a` at this edge; stay in IDLE.
  - NONE: no effect.
- RUN: `cnt` decrements each edge. On the edge where `cnt==1`: commit `hi<=p_hi`, `lo<=p_lo`, go to IDLE.
- `start` in RUN is ignored entirely; this includes MTHI/MTLO. The stall controller guarantees it does not occur. The bench checks that it is ignored.
- Arithmetic:
  - MULT: signed 32×32→64; HI = upper word, LO = lower word.
  - MULTU: unsigned 32×32→64, same split.
  - DIV: signed, quotient truncated toward zero → LO; remainder carries the dividend's sign → HI.
  - DIVU: unsigned; quotient → LO, remainder → HI.
- `0x80000000 DIV 0xFFFFFFFF` gives LO=0x80000000, HI=0.
- Divide by zero (`src_b==0`): unit still goes busy for DIV_CYCLES, but HI and LO stay unchanged at commit.
- `busy` = (state==RUN). It is registered, with no combinational path from `start`. The stall controller ORs in `start` itself.

## Timing
- Reset (`rst_n=0`, any time, including mid-RUN): immediately `hi=0`, `lo=0`, `busy=0`, state IDLE, `cnt=0`; pending result discarded.
- Multi-cycle op started at edge k:
  - `busy` reads 1 after edge k through edge k+N−1, where N is the op's latency parameter.
  - At edge k+N, new HI/LO become visible and `busy` falls.
  - A new `start` is accepted at edge k+N, the same edge `busy` falls.
- MTHI/MTLO: value visible one edge after `start`. `busy` never asserts.
- Back-to-back starts in IDLE on consecutive edges: each is accepted in order. Because an accepted multi-cycle op moves the unit to RUN, only MT* ops can chain on consecutive edges.
- `hi`/`lo` are driven straight from registers. They never glitch mid-RUN and hold their old values until commit.

## Structure
- The `MDU_*` op encodings (3-bit) belong in the shared macro header, next to the Tnew/forward-select constants. The decoder and stall controller use the same names.
- Latency defaults appear only as parameters and are not duplicated in the header.
- Natural sub-module: `mdu_calc`, purely combinational. It takes `md_op`, `src_a`, `src_b` and produces the 64-bit `{res_hi,res_lo}` plus a `div_zero` flag. `mult_div_unit` holds the FSM, counter and HI/LO/pending registers.

## Test plan
- Reset then MULT with `src_a=0xFFFFFFFE` (−2), `src_b=3` → `busy` high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU with `src_a=0xFFFFFFFF`, `src_b=0xFFFFFFFF` → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV with `src_a=−7`, `src_b=2` → `busy` 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU with `src_a=7`, `src_b=0` → HI/LO unchanged after 10 busy cycles.
- MTHI with 0x12345678, next cycle MTLO with 0x9ABCDEF0 → each visible one cycle after its start; `busy` stays 0. Then a MTHI issued during a DIV's RUN → ignored; HI at commit equals the division remainder.
- DIV started, `rst_n` pulsed low at busy cycle 4 → HI=LO=0 and `busy=0` immediately. The aborted result never appears, and a new MULT after release completes normally.
- MULT accepted on the exact edge `busy` falls from a prior DIV → DIV result is committed and the new MULT's busy window starts with no gap.
